// File: rtl/mips_pipeline_immediate_stage_pkg.sv
// Shared MIPS immediate-control definitions: bundle layout, field encodings and
// the skid-stage state encoding.
package mips_pipeline_immediate_stage_pkg;

  localparam int CTRL_W          = 2;
  localparam int CTRL_EXTEND_BIT = 0;
  localparam int CTRL_SHIFT_BIT  = 1;

  typedef enum logic {
    EXTEND_SIGNED   = 1'b0,
    EXTEND_UNSIGNED = 1'b1
  } extend_e;

  typedef enum logic {
    SHIFT_NONE    = 1'b0,
    SHIFT_LEFT16  = 1'b1
  } shift_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  function automatic extend_e ctrl_extend(input logic [CTRL_W-1:0] ctrl);
    return extend_e'(ctrl[CTRL_EXTEND_BIT]);
  endfunction

  function automatic shift_e ctrl_shift(input logic [CTRL_W-1:0] ctrl);
    return shift_e'(ctrl[CTRL_SHIFT_BIT]);
  endfunction

endpackage

// File: rtl/mips_pipeline_immediate_stage_if.sv
// Stream bundle between decode, the immediate stage and execute; dbg_state
// exposes the skid-buffer occupancy.
interface mips_pipeline_immediate_stage_if #(
  parameter int TAG_WIDTH  = 8,
  parameter int DATA_WIDTH = 32
);
  import mips_pipeline_immediate_stage_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  logic [15:0]           in_imm16;
  logic [CTRL_W-1:0]     in_control;
  logic [TAG_WIDTH-1:0]  in_tag;
  logic                  flush;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_imm;
  logic [TAG_WIDTH-1:0]  out_tag;
  state_e                dbg_state;

  modport slave (
    input  in_valid, in_imm16, in_control, in_tag, flush, out_ready,
    output in_ready, out_valid, out_imm, out_tag, dbg_state
  );

  modport master (
    output in_valid, in_imm16, in_control, in_tag, flush, out_ready,
    input  in_ready, out_valid, out_imm, out_tag, dbg_state
  );

endinterface

// File: rtl/mips_pipeline_immediate_stage_form.sv
// Combinational formation of the 32-bit operand from imm16 and the control
// bundle; Left16 places imm16 in the upper half and ignores extend.
module mips_immediate_form
  import mips_pipeline_immediate_stage_pkg::*;
(
  input  logic [15:0]       i_imm16,
  input  logic [CTRL_W-1:0] i_control,
  output logic [31:0]       o_imm
);

  always_comb begin
    o_imm = {{16{i_imm16[15]}}, i_imm16};
    if (ctrl_shift(i_control) == SHIFT_LEFT16) begin
      o_imm = {i_imm16, 16'h0000};
    end else if (ctrl_extend(i_control) == EXTEND_UNSIGNED) begin
      o_imm = {16'h0000, i_imm16};
    end
  end

endmodule

// File: rtl/mips_pipeline_immediate_stage.sv
// Decode-to-execute immediate stage: forms the operand and holds it in a
// two-entry skid buffer (main + skid) with flush support.
module mips_pipeline_immediate_stage
  import mips_pipeline_immediate_stage_pkg::*;
#(
  parameter int TAG_WIDTH  = 8,
  parameter int DATA_WIDTH = 32
) (
  input logic clock,
  input logic reset,
  mips_pipeline_immediate_stage_if.slave bus
);

  generate
    if (DATA_WIDTH != 32) begin : g_bad_data_width
      $error("mips_pipeline_immediate_stage: DATA_WIDTH must be 32");
    end
  endgenerate

  // Handshake: a beat moves on a side when valid && ready at the rising edge;
  // valid never depends on ready, and in_ready is a function of state only.
  state_e                r_state;
  state_e                w_state_next;
  logic                  w_accept;
  logic                  w_drain;
  logic                  w_load_main;
  logic                  w_load_skid;
  logic                  w_skid_to_main;
  logic [31:0]           w_imm;
  logic [DATA_WIDTH-1:0] r_main_imm;
  logic [DATA_WIDTH-1:0] r_skid_imm;
  logic [TAG_WIDTH-1:0]  r_main_tag;
  logic [TAG_WIDTH-1:0]  r_skid_tag;

  mips_immediate_form u_form (
    .i_imm16   (bus.in_imm16),
    .i_control (bus.in_control),
    .o_imm     (w_imm)
  );

  assign bus.in_ready  = (r_state != ST_TWO);
  assign bus.out_valid = (r_state != ST_EMPTY);
  assign bus.out_imm   = r_main_imm;
  assign bus.out_tag   = r_main_tag;
  assign bus.dbg_state = r_state;

  assign w_accept = bus.in_valid && bus.in_ready;
  assign w_drain  = bus.out_valid && bus.out_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_load_main    = 1'b0;
    w_load_skid    = 1'b0;
    w_skid_to_main = 1'b0;
    if (bus.flush) begin
      w_state_next = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            w_state_next = ST_ONE;
            w_load_main  = 1'b1;
          end
        end
        ST_ONE: begin
          if (w_accept && w_drain) begin
            w_load_main = 1'b1;
          end else if (w_accept) begin
            w_state_next = ST_TWO;
            w_load_skid  = 1'b1;
          end else if (w_drain) begin
            w_state_next = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (w_drain) begin
            w_state_next   = ST_ONE;
            w_skid_to_main = 1'b1;
          end
        end
        default: w_state_next = ST_EMPTY;
      endcase
    end
  end

  // Data registers move only on their load enables, so held output is stable.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_main_imm <= '0;
      r_main_tag <= '0;
      r_skid_imm <= '0;
      r_skid_tag <= '0;
    end else begin
      if (w_skid_to_main) begin
        r_main_imm <= r_skid_imm;
        r_main_tag <= r_skid_tag;
      end else if (w_load_main) begin
        r_main_imm <= w_imm;
        r_main_tag <= bus.in_tag;
      end
      if (w_load_skid) begin
        r_skid_imm <= w_imm;
        r_skid_tag <= bus.in_tag;
      end
    end
  end

endmodule

// File: doc/mips_pipeline_immediate_stage.md
Name: mips_pipeline_immediate_stage

Overview:
Decode-to-execute pipeline stage that consumes the immediate control bundle (extend, shift) produced by the immediate control-signal generator, together with the raw 16-bit instruction immediate. It forms the 32-bit operand and registers it with a two-entry skid buffer, giving full-throughput valid/ready handshaking, stall tolerance and flush support. The output feeds the ALU operand-B mux in execute.

Parameters:
TAG_WIDTH, 8, width of the opaque instruction tag carried alongside the immediate (pipeline slot / PC index).
DATA_WIDTH, 32, output immediate width; fixed at 32, any other value is a configuration error flagged at elaboration.

Ports:
clock  input  1  single system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
in_valid  input  1  upstream holds a valid immediate this cycle.
in_ready  output  1  stage can accept; a transfer happens when in_valid && in_ready.
in_imm16  input  16  raw instruction immediate field [15:0].
in_control  input  2  immediate control bundle: bit0 extend (0 Signed, 1 Unsigned), bit1 shift (0 None, 1 Left16).
in_tag  input  TAG_WIDTH  instruction tag, passed through unchanged.
flush  input  1  squash all held entries (branch mispredict / exception).
out_valid  output  1  out_imm/out_tag valid.
out_ready  input  1  downstream accepts; transfer when out_valid && out_ready.
out_imm  output  32  formed immediate.
out_tag  output  TAG_WIDTH  tag of the entry on out_imm.

Behaviour:
- Reset (asynchronous, active-high): main and skid entries invalid, out_valid=0, out_imm=0, out_tag=0, in_ready=1 after reset deasserts. Reset mid-transfer discards all entries; no partial results emerge.
- Formation (combinational, at input side, before registering):
  - shift=Left16: imm = {imm16, 16'h0000}; extend is ignored.
  - shift=None, extend=Signed: imm = {{16{imm16[15]}}, imm16}.
  - shift=None, extend=Unsigned: imm = {16'h0000, imm16}.
- Latency: exactly 1 cycle from accepted input to out_valid, when the stage is empty or draining.
- States: EMPTY (no entry), ONE (main valid), TWO (main and skid valid).
  - EMPTY: accept -> ONE.
  - ONE: accept and no drain -> TWO (entry goes to skid); accept and drain -> ONE (main replaced); drain only -> EMPTY; neither -> ONE.
  - TWO: drain -> ONE (skid moves to main); no drain -> TWO. No accept is possible because in_ready=0.
- in_ready = !skid_valid, driven from a register; no combinational path from out_ready to in_ready.
- out_valid = main_valid; out_imm/out_tag are driven from main registers only.
- Ordering is strict FIFO; the tag always travels with its immediate.
- Output data holds stable while out_valid && !out_ready.
- Flush: next state is EMPTY regardless of other inputs. An input presented in the flush cycle is dropped even if in_ready=1. A drain in the flush cycle still counts as completed downstream. Data registers may hold stale values, but out_valid must be 0.
- Flush and reset together: reset dominates; the result is identical.
- Data registers update only on the load enable. Valid bits are the only state reset is required to clear, but data registers are also reset to 0.

Decomposition:
- Shared package (Mips control/immediate constants): control bundle width (2), field bit positions, and the encodings Extend_Signed=0, Extend_Unsigned=1, Shift_None=0, Shift_Left16=1. These must be the same definitions the control generator uses.
- One sub-module, mips_immediate_form: pure combinational imm16+control -> imm32. It is reused by the bench as the reference model.
- The skid buffer is kept inline in this module.

Test Plan:
- Formation sweep, out_ready=1: imm16=16'h8001 with ctrl Signed/None -> 32'hFFFF8001; Unsigned/None -> 32'h00008001; Signed/Left16 -> 32'h80010000; Unsigned/Left16 -> 32'h80010000. Each appears 1 cycle after acceptance.
- Back-to-back streaming, out_ready=1: 8 consecutive inputs, tags 0..7 -> 8 outputs in order on consecutive cycles; in_ready stays 1 throughout.
- Backpressure: out_ready=0 while presenting tags 1, 2, 3 -> tags 1 and 2 accepted, in_ready=0 the cycle after the 2nd accept, tag 3 held upstream. Raise out_ready -> outputs 1, 2, 3 in order, out_imm stable during the stall.
- Flush in state TWO, with in_valid=1 in the same cycle -> next cycle out_valid=0, in_ready=1; the flush-cycle input never appears at the output.
- Async reset asserted mid-stream between clock edges -> out_valid, out_imm, out_tag go to 0 immediately; in_ready=1 after release; the first post-reset input emerges with 1-cycle latency.
- Lui-style and logic-style cases: imm16=16'h1234 with Left16 -> 32'h12340000; imm16=16'hFFFF with Unsigned/None -> 32'h0000FFFF.
